// File: rtl/bootrom_arb_pkg.sv
// Shared constants and sizing helpers for the boot ROM arbiter.
// Range checking is enabled by defining BOOTROM_ARB_RANGE_CHECK_EN.
package bootrom_arb_pkg;

    // Width of a requester index: clog2(n), never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of byte-offset bits within one ROM word.
    function automatic int unsigned word_offset(input int unsigned data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 0;
    endfunction

endpackage

// File: rtl/bootrom_arb_rr.sv
// Round-robin pointer plus first-set-from-pointer priority encoder.
module bootrom_arb_rr #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              gnt_taken_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] win_hi, win_lo;
    logic            found_hi, found_lo;

    // Two passes: the first asserted request at or above the pointer, else the lowest one.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (req_i[j] && !found_hi && (j >= 32'(ptr_q))) begin
                found_hi = 1'b1;
                win_hi   = IdxW'(j);
            end
            if (req_i[j] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = IdxW'(j);
            end
        end
    end

    assign idx_o = found_hi ? win_hi : win_lo;
    assign gnt_o = (found_hi || found_lo) ? (NumReq'(1) << idx_o) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_taken_i) begin
            ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// Shares a combinational-read boot ROM between NumReq word-read requesters.
// Define BOOTROM_ARB_RANGE_CHECK_EN to flag granted addresses >= RomSizeBytes.
module bootrom_arbiter
    import bootrom_arb_pkg::*;
#(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RomSizeBytes = 4096
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0] addr_i,
    output logic [NumReq-1:0]                gnt_o,
    output logic [NumReq-1:0]                rvalid_o,
    output logic [DataWidth-1:0]             rdata_o,
    output logic [NumReq-1:0]                err_o,
    output logic                             rom_req_o,
    output logic [AddrWidth-1:0]             rom_addr_o,
    input  logic [DataWidth-1:0]             rom_data_i
);

    localparam int unsigned IdxW = idx_width(NumReq);

    logic [IdxW-1:0]      win_idx;
    logic                 any_gnt;
    logic [AddrWidth-1:0] sel_addr;

    assign any_gnt = |gnt_o;

    bootrom_arb_rr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_taken_i (any_gnt),
        .gnt_o       (gnt_o),
        .idx_o       (win_idx)
    );

    assign sel_addr = addr_i[win_idx];

`ifdef BOOTROM_ARB_RANGE_CHECK_EN
    logic in_range;

    // Out-of-range grants still complete, but never touch the ROM.
    assign in_range  = 64'(sel_addr) < 64'(RomSizeBytes);
    assign rom_req_o = any_gnt & in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= '0;
        end else begin
            err_o <= (any_gnt && !in_range) ? gnt_o : '0;
        end
    end
`else
    assign rom_req_o = any_gnt;
    assign err_o     = '0;
`endif

    assign rom_addr_o = rom_req_o ? sel_addr : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o;
            if (any_gnt) begin
                rdata_o <= rom_req_o ? rom_data_i : '0;
            end
        end
    end

endmodule

// File: doc/bootrom_arbiter.md
Name: bootrom_arbiter

Overview:
- Shares the single-port, combinational-read boot ROM between several word-read requesters, e.g. the debug-module system bus port and a core fetch port.
- Uses a req/gnt/rvalid protocol with round-robin arbitration.
- Registers ROM read data and routes it back to the granted requester one cycle after the grant.
- Sits between the debug/core masters and the boot ROM instance in the chip top.

Parameters:
- NumReq, 2, number of requesters (≥1).
- AddrWidth, 16, byte address width toward the ROM.
- DataWidth, 32, ROM word width.
- RomSizeBytes, 4096, bytes of populated ROM; used only by the optional range check.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumReq  per-requester read request.
- addr_i  in  NumReq x AddrWidth  per-requester byte address.
- gnt_o  out  NumReq  one-hot grant, combinational.
- rvalid_o  out  NumReq  one-hot response valid, registered.
- rdata_o  out  DataWidth  shared response data, registered.
- err_o  out  NumReq  per-requester response error, registered.
- rom_req_o  out  1  ROM access strobe.
- rom_addr_o  out  AddrWidth  ROM byte address.
- rom_data_i  in  DataWidth  ROM data, combinational on rom_addr_o.

Interface decision: reset rst_ni, asynchronous, active-low; clock clk_i.

Behaviour:
- Reset values: rvalid_o=0, err_o=0, rdata_o=0, round-robin pointer=0. gnt_o=0 and rom_req_o=0 whenever no req_i is high.
- Requester rule: once req_i[i] is raised, it and addr_i[i] must stay stable until gnt_o[i]=1. A request is consumed in the grant cycle.
- Arbitration:
  - Scan starts at the pointer, ascending with wrap from NumReq-1 to 0; the first asserted req_i wins.
  - Winner: gnt_o[w]=1, rom_req_o=1, rom_addr_o=addr_i[w], same cycle as the request (zero-cycle grant possible).
  - At most one grant per cycle.
- Pointer update:
  - On a grant, the pointer becomes (w+1) mod NumReq.
  - With no grant, the pointer holds.
  - A pointer value is encoded so it is always < NumReq. With NumReq=1 the pointer is constant 0.
- Response stage (one register):
  - At the clock edge after a grant: rdata_o<=rom_data_i, rvalid_o<=onehot(w), err_o<=0.
  - With no grant: rvalid_o<=0, err_o<=0, rdata_o holds its last value.
- Latency and throughput:
  - Exactly 1 cycle from grant to rvalid.
  - 1 grant per cycle sustained; a new grant and the previous rvalid may coincide.
  - No backpressure on responses: a requester must accept rvalid the cycle it occurs.
- Address handling: the ROM is word-read; addr_i bits [log2(DataWidth/8)-1:0] are passed through unchanged and ignored by the ROM.
- Reset mid-operation: any pending response is dropped and no rvalid follows. The pointer returns to 0.
- X safety: when rom_req_o=0, rom_addr_o is driven 0.

Optional Feature:
- Macro BOOTROM_ARB_RANGE_CHECK_EN, compiled in:
  - A granted address ≥ RomSizeBytes is still granted, but rom_req_o stays 0.
  - Next cycle: rvalid_o[w]=1, err_o[w]=1, rdata_o=0.
  - The pointer advances normally.
- Macro absent:
  - No range check; every grant accesses the ROM.
  - err_o is tied to 0 and RomSizeBytes is unused.

Decomposition:
- Shared package bootrom_arb_pkg holds:
  - the requester index width constant (clog2 of NumReq, minimum 1);
  - the word-offset constant.
- One natural sub-module, bootrom_arb_rr: round-robin pointer plus first-set-from-pointer priority encoder.
  - Inputs: req vector, grant-taken.
  - Outputs: one-hot grant, winner index.
- bootrom_arbiter itself adds the ROM muxing and the response register.

Test Plan (NumReq=2, AddrWidth=16, DataWidth=32, RomSizeBytes=4096):
1. Single request: req_i=2'b01, addr_i[0]=16'h0010 → same cycle gnt_o=2'b01, rom_req_o=1, rom_addr_o=16'h0010; next cycle rvalid_o=2'b01, rdata_o=ROM word 4.
2. Contention and fairness: req_i=2'b11 held for 4 cycles from reset → grants 01,10,01,10; rvalid_o follows each grant by 1 cycle, with matching data.
3. Back-to-back from one requester: req_i[1] high for 3 cycles with addresses 0x0,0x4,0x8 and req_i[0] low → 3 consecutive grants to requester 1; rvalid_o[1] high for 3 consecutive cycles with words 0,1,2.
4. Reset mid-operation: grant at cycle N, rst_ni low before edge N+1 → rvalid_o=0 at N+1; the first grant after release goes to requester 0 when both request.
5. Idle and hold: requests drop after one response → rvalid_o=0, rdata_o holds the last value, rom_req_o=0, rom_addr_o=0.
6. Range check (BOOTROM_ARB_RANGE_CHECK_EN defined): addr_i[0]=16'h1000 → gnt_o[0]=1 with rom_req_o=0; next cycle rvalid_o[0]=1, err_o[0]=1, rdata_o=0. With the macro undefined the same stimulus gives rom_req_o=1 and err_o=0.
